ls299: RTL

- Behavioural model of the LS299 8-bit universal shift/storage register with 3-state I/O, for the System86 TTL library.
- It is the read-back/driver end of a bus register. It parallel-loads from a shared data bus, shifts serially in either direction, and drives its contents back onto the bus.
- The bidirectional I/O pins are split into in, out and enable signals so the model is FPGA-synthesisable.
- The board-level wrapper resolves the tri-state bus.

---
 rtl/ls299.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ls299.sv
// ---------------------------------------------------------------------------
// ls299 -- 8-bit universal shift/storage register with 3-state I/O (LS299)
//
// Read-back/driver end of a bus register. Parallel-loads from a shared data
// bus, shifts serially in either direction, and drives its contents back onto
// the bus. The bidirectional I/O pins are split into IO_I / IO_O / IO_OE; the
// board-level wrapper resolves the tri-state bus.
//
// Ports:
//   CLK    in   1      clock, register updates on rising edge
//   nCLR   in   1      asynchronous active-low clear
//   S0,S1  in   1      mode select {S1,S0}: 00 hold, 01 shift right,
//                      10 shift left, 11 parallel load
//   nG1    in   1      output enable 1, active-low
//   nG2    in   1      output enable 2, active-low
//   DS0    in   1      serial input for shift right (enters Q[0])
//   DS7    in   1      serial input for shift left (enters Q[WIDTH-1])
//   IO_I   in   WIDTH  bus value sampled during parallel load
//   IO_O   out  WIDTH  register contents presented to the bus (never gated)
//   IO_OE  out  1      bus drive enable, 1 = drive IO_O onto the bus
//   Q0S    out  1      serial output, always Q[0] (not tri-stated)
//   Q7S    out  1      serial output, always Q[WIDTH-1] (not tri-stated)
//
// Parameters:
//   WIDTH      register width (only 8 for board use)
//   TPD_CLK_Q  clock/clear-to-output delay in ns (LS299_DELAY_EN only)
//   TPD_OE     output-enable/disable delay in ns (LS299_DELAY_EN only)
//
// Configuration macro:
//   LS299_DELAY_EN  when defined, outputs follow their sources after
//                   transport delays (simulation only). When undefined the
//                   model is zero-delay and synthesisable.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module ls299 #(
    parameter int unsigned WIDTH     = 8,
    parameter int          TPD_CLK_Q = 22,
    parameter int          TPD_OE    = 18
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             S0,
    input  logic             S1,
    input  logic             nG1,
    input  logic             nG2,
    input  logic             DS0,
    input  logic             DS7,
    input  logic [WIDTH-1:0] IO_I,
    output logic [WIDTH-1:0] IO_O,
    output logic             IO_OE,
    output logic             Q0S,
    output logic             Q7S
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Elaboration-time sanity checks on the configuration.
    if (WIDTH < 2) begin : g_bad_width
        $error("ls299: WIDTH must be at least 2");
    end
    if (TPD_CLK_Q < 0 || TPD_OE < 0) begin : g_bad_delay
        $error("ls299: delay parameters must be non-negative");
    end

    mode_e            w_mode;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_oe;
    logic [WIDTH-1:0] r_q;

    assign w_mode = mode_e'({S1, S0});

    // Shift right moves data toward the MSB (Q[n] <= Q[n-1]); shift left
    // moves it toward the LSB. X/Z on the mode pins falls through to the
    // default and poisons Q so the fault is visible in simulation.
    always_comb begin
        w_q_nxt = r_q;
        case (w_mode)
            MODE_HOLD: w_q_nxt = r_q;
            MODE_SHR:  w_q_nxt = {r_q[WIDTH-2:0], DS0};
            MODE_SHL:  w_q_nxt = {DS7, r_q[WIDTH-1:1]};
            MODE_LOAD: w_q_nxt = IO_I;
            default:   w_q_nxt = 'x;
        endcase
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    // Drive is suppressed during parallel load so the device never drives
    // the bus it is sampling. Purely combinational; nCLR has no influence.
    assign w_oe = ~nG1 & ~nG2 & ~(S1 & S0);

`ifdef LS299_DELAY_EN
    // Non-blocking intra-assignment delays give transport behaviour: every
    // source change is replayed at the output after the full delay.
    always @(r_q) begin
        IO_O <= #(TPD_CLK_Q) r_q;
        Q0S  <= #(TPD_CLK_Q) r_q[0];
        Q7S  <= #(TPD_CLK_Q) r_q[WIDTH-1];
    end

    always @(w_oe) begin
        IO_OE <= #(TPD_OE) w_oe;
    end
`else
    assign IO_O  = r_q;
    assign Q0S   = r_q[0];
    assign Q7S   = r_q[WIDTH-1];
    assign IO_OE = w_oe;
`endif

endmodule
